time_keeper: RTL and testbench
==============================

Name: time_keeper

Overview:
- Downstream consumer of the clock divider's slow clock output (clk_1hz).
- Runs entirely on the system clock and treats clk_1hz as a data level: synchronises it, edge-detects it and advances an HH:MM:SS BCD time-of-day count.
- Provides a set mode for adjusting minutes and hours.
- Its BCD digit outputs feed the seven-segment display scanner.

Parameters:
- SYNC_STAGES, 2, number of flops in the tick_in synchroniser (min 2).
- RESET_HR, 0, hour value loaded at reset (decimal 0..23).
- RESET_MIN, 0, minute value loaded at reset (decimal 0..59).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- tick_in  in  1  clk_1hz level from the clock divider, asynchronous to clk for design purposes.
- run_en  in  1  1 = time advances on ticks; 0 = paused.
- set_mode  in  1  1 = adjust mode.
- inc_min  in  1  single-cycle pulse, pre-debounced.
- inc_hr  in  1  single-cycle pulse, pre-debounced.
- sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens  out  4 each  BCD digits.
- sec_pulse  out  1  one-cycle strobe each time seconds advance.
- day_pulse  out  1  one-cycle strobe on the 23:59:59 to 00:00:00 rollover.

Behaviour:
- Reset (async, rst_n low):
  - Seconds = 00; minutes = RESET_MIN; hours = RESET_HR, all in BCD.
  - sec_pulse = 0, day_pulse = 0; synchroniser and edge flops = 0.
- Tick detection:
  - tick_in passes through SYNC_STAGES flops plus one history flop.
  - tick = sync_out & ~history.
  - With SYNC_STAGES=2, the digits update on the 3rd rising clk edge after tick_in rises, given setup is met.
  - Only rising edges count; falling edges are ignored.
- Run state (set_mode=0, run_en=1), on each tick:
  - Seconds increment 00..59.
  - At 59, seconds wrap to 00 and minutes increment; minutes 59 wrap to 00 and hours increment; hours 23 wrap to 00.
  - sec_pulse asserts in the same cycle the seconds register updates.
  - day_pulse asserts in the same cycle as the 23:59:59 to 00:00:00 update.
  - Each strobe lasts exactly 1 cycle.
- Pause (run_en=0, set_mode=0):
  - Ticks are dropped, not queued. Digits hold; no strobes.
- Set state (set_mode=1):
  - Ticks are ignored.
  - Seconds are forced to 00 on the first cycle set_mode is sampled high and held there.
  - inc_min: minutes +1 mod 60, no carry into hours.
  - inc_hr: hours +1 mod 24, no day_pulse.
  - inc_min and inc_hr in the same cycle: both apply.
  - Pulses held high for N cycles give N increments.
  - inc_min/inc_hr are ignored when set_mode=0.
- Leaving set mode:
  - Counting resumes from HH:MM:00 on the next tick.
  - A tick coinciding with the set_mode falling edge is treated as a run-state tick only if set_mode is sampled 0 in that cycle.
- Arithmetic:
  - Each ones digit is 0..9 with carry into its tens digit.
  - Tens limits: seconds/minutes 0..5, hours 0..2; hours wrap at tens=2, ones=3.
  - Digits never hold a non-BCD value.
- Reset mid-operation: immediate async clear to the reset values, including any strobe in flight.

Optional Feature:
- Macro: TWELVE_HOUR_EN.
- When defined:
  - Hours run 12, 01..11; reset hour is 12 and RESET_HR is ignored.
  - Extra output pm (1 bit) resets to 0 and toggles when the count goes 11:59:59 to 12:00:00.
  - inc_hr steps 11 to 12 and toggles pm.
  - day_pulse fires on 11:59:59 PM to 12:00:00 AM.
- When undefined: 24-hour behaviour as above; no pm port.

Decomposition:
- Shared package time_pkg:
  - BCD digit width constant (4).
  - Limits SEC_MAX=59, MIN_MAX=59, HR_MAX_24=23, HR_MAX_12=12.
  - Typedef for the two-digit BCD pair.
- Sub-module bcd_mod_counter:
  - Parameterised two-digit BCD counter with modulus, inc input, clear input and wrap/carry output.
  - Instantiated three times (seconds, minutes, hours).

Test Plan:
- Reset: hold rst_n=0 with tick_in toggling, release -> 00:00:00 with defaults; no sec_pulse until the first tick_in rise, then sec_ones=1 on the 3rd clk edge.
- Minute carry: set time to 00:00:59 via set mode and ticks, apply 1 tick -> 00:01:00, one sec_pulse, no day_pulse.
- Day rollover: reach 23:59:59, apply 1 tick -> 00:00:00 and day_pulse high for exactly 1 cycle, coincident with sec_pulse.
- Set mode: at 10:20:35 raise set_mode -> seconds 00 next cycle; inc_min x45 -> minutes 05, hours still 10; inc_hr+inc_min same cycle -> 11:06:00; ticks ignored.
- Pause and glitch: run_en=0 for 5 ticks -> digits unchanged; tick_in pulse narrower than 1 clk period -> at most 1 increment; async rst_n assertion mid-count -> immediate reset values.
- TWELVE_HOUR_EN: from 11:59:59 AM apply 1 tick -> 12:00:00, pm=1; from 12:59:59 apply 1 tick -> 01:00:00, pm unchanged.

Source files
------------

// File: rtl/time_pkg.sv
// Shared constants and types for the time-of-day counter: BCD digit width,
// field limits and the two-digit BCD pair used by every counter stage.
package time_pkg;

  localparam int DIGIT_W   = 4;
  localparam int SEC_MAX   = 59;
  localparam int MIN_MAX   = 59;
  localparam int HR_MAX_24 = 23;
  localparam int HR_MAX_12 = 12;

  typedef struct packed {
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
  } bcd_pair_t;

  function automatic bcd_pair_t to_bcd(input int unsigned val);
    bcd_pair_t p;
    p.tens = DIGIT_W'(val / 10);
    p.ones = DIGIT_W'(val % 10);
    return p;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter running MIN_VAL..MAX_VAL (modulus MAX_VAL-MIN_VAL+1).
// at_max is the carry condition: the next inc wraps back to MIN_VAL.
module bcd_mod_counter
  import time_pkg::*;
#(
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 59,
  parameter int RST_VAL = 0
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      inc,
  input  logic      clr,
  output bcd_pair_t value,
  output logic      at_max
);

  localparam bcd_pair_t MIN_BCD = to_bcd(MIN_VAL);
  localparam bcd_pair_t MAX_BCD = to_bcd(MAX_VAL);
  localparam bcd_pair_t RST_BCD = to_bcd(RST_VAL);

  bcd_pair_t cnt_q;
  bcd_pair_t cnt_d;

  assign at_max = (cnt_q == MAX_BCD);
  assign value  = cnt_q;

  // clr wins over inc so a held clear pins the value at MIN_VAL
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = MIN_BCD;
    end else if (inc) begin
      if (at_max) begin
        cnt_d = MIN_BCD;
      end else if (cnt_q.ones == DIGIT_W'(9)) begin
        cnt_d.ones = '0;
        cnt_d.tens = cnt_q.tens + DIGIT_W'(1);
      end else begin
        cnt_d.ones = cnt_q.ones + DIGIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= RST_BCD;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/time_keeper.sv
// HH:MM:SS BCD time-of-day keeper advanced by rising edges of a slow tick level.
// Define TWELVE_HOUR_EN for 12-hour display (12,01..11) with a pm output.
module time_keeper
  import time_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RESET_HR    = 0,
  parameter int RESET_MIN   = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_in,
  input  logic               run_en,
  input  logic               set_mode,
  input  logic               inc_min,
  input  logic               inc_hr,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] hr_ones,
  output logic [DIGIT_W-1:0] hr_tens,
  output logic               sec_pulse,
  output logic               day_pulse
`ifdef TWELVE_HOUR_EN
  ,
  output logic               pm
`endif
);

`ifdef TWELVE_HOUR_EN
  localparam int HR_MIN = 1;
  localparam int HR_TOP = HR_MAX_12;
  localparam int HR_RST = HR_MAX_12;
  localparam bcd_pair_t HR_ELEVEN = to_bcd(11);
`else
  localparam int HR_MIN = 0;
  localparam int HR_TOP = HR_MAX_24;
  localparam int HR_RST = RESET_HR;
`endif

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   tick;
  logic                   run_tick;
  logic                   sec_wrap;
  logic                   min_inc;
  logic                   hr_inc;
  logic                   roll;
  logic                   sec_at_max;
  logic                   min_at_max;
  logic                   hr_at_max;
  bcd_pair_t              sec_val;
  bcd_pair_t              min_val;
  bcd_pair_t              hr_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // The edge detector keeps running in set/pause so no stale tick is replayed later
  assign tick     = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign run_tick = tick & run_en & ~set_mode;
  assign sec_wrap = run_tick & sec_at_max;
  assign min_inc  = sec_wrap | (set_mode & inc_min);
  // Hours use min_at_max, not a minute wrap, so set-mode minute wraps never carry
  assign hr_inc   = (sec_wrap & min_at_max) | (set_mode & inc_hr);

  bcd_mod_counter #(
    .MIN_VAL(0),
    .MAX_VAL(SEC_MAX),
    .RST_VAL(0)
  ) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (run_tick),
    .clr   (set_mode),
    .value (sec_val),
    .at_max(sec_at_max)
  );

  bcd_mod_counter #(
    .MIN_VAL(0),
    .MAX_VAL(MIN_MAX),
    .RST_VAL(RESET_MIN)
  ) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (min_inc),
    .clr   (1'b0),
    .value (min_val),
    .at_max(min_at_max)
  );

  bcd_mod_counter #(
    .MIN_VAL(HR_MIN),
    .MAX_VAL(HR_TOP),
    .RST_VAL(HR_RST)
  ) u_hr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hr_inc),
    .clr   (1'b0),
    .value (hr_val),
    .at_max(hr_at_max)
  );

`ifdef TWELVE_HOUR_EN
  logic pm_q;

  // Any step from 11 to 12, counted or manual, flips AM/PM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          pm_q <= 1'b0;
    else if (hr_inc && hr_val == HR_ELEVEN) pm_q <= ~pm_q;
  end

  assign pm   = pm_q;
  assign roll = sec_wrap & min_at_max & (hr_val == HR_ELEVEN) & pm_q;
`else
  assign roll = sec_wrap & min_at_max & hr_at_max;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_pulse <= 1'b0;
      day_pulse <= 1'b0;
    end else begin
      sec_pulse <= run_tick;
      day_pulse <= roll;
    end
  end

  assign sec_ones = sec_val.ones;
  assign sec_tens = sec_val.tens;
  assign min_ones = min_val.ones;
  assign min_tens = min_val.tens;
  assign hr_ones  = hr_val.ones;
  assign hr_tens  = hr_val.tens;

endmodule

// File: tb/tb_time_keeper.sv
// Self-checking bench for time_keeper: directed scenarios plus random operations
// compared against a seconds-of-day reference model.
module tb_time_keeper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_in = 1'b0;
  logic       run_en = 1'b0;
  logic       set_mode = 1'b0;
  logic       inc_min = 1'b0;
  logic       inc_hr = 1'b0;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens;
  logic       sec_pulse, day_pulse;
`ifdef TWELVE_HOUR_EN
  logic       pm;
`endif
  logic [23:0] dut_digits;

  time_keeper dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_in  (tick_in),
    .run_en   (run_en),
    .set_mode (set_mode),
    .inc_min  (inc_min),
    .inc_hr   (inc_hr),
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .min_ones (min_ones),
    .min_tens (min_tens),
    .hr_ones  (hr_ones),
    .hr_tens  (hr_tens),
    .sec_pulse(sec_pulse),
    .day_pulse(day_pulse)
`ifdef TWELVE_HOUR_EN
    ,
    .pm       (pm)
`endif
  );

  assign dut_digits = {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones};

  // clock / reset
  always #5 clk = ~clk;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          tod = 0;          // reference: seconds since midnight
  int          sec_seen = 0;
  int          day_seen = 0;
  int          day_alone = 0;
  logic [23:0] exp_q[$];

  always @(negedge clk) begin
    if (sec_pulse === 1'b1) sec_seen++;
    if (day_pulse === 1'b1) day_seen++;
    if (day_pulse === 1'b1 && sec_pulse !== 1'b1) day_alone++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic logic [23:0] model_digits();
    int h, m, s, hd;
    h = tod / 3600;
    m = (tod / 60) % 60;
    s = tod % 60;
`ifdef TWELVE_HOUR_EN
    hd = (h % 12 == 0) ? 12 : h % 12;
`else
    hd = h;
`endif
    return {4'(hd / 10), 4'(hd % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic model_inc(input bit im, input bit ih);
    int h, m, s;
    h = tod / 3600;
    m = (tod / 60) % 60;
    s = tod % 60;
    if (im) m = (m + 1) % 60;
    if (ih) h = (h + 1) % 24;
    tod = h * 3600 + m * 60 + s;
  endtask

  task automatic check_time(input string tag);
    exp_q.push_back(model_digits());
    check(tag, dut_digits, exp_q.pop_front());
`ifdef TWELVE_HOUR_EN
    check({tag, "_pm"}, pm, (tod >= 12 * 3600));
`endif
  endtask

  // driver tasks
  task automatic do_tick(input string tag);
    int s0, d0;
    bit adv, day;
    adv = run_en && !set_mode;
    day = adv && (tod == 86399);
    s0 = sec_seen;
    d0 = day_seen;
    @(negedge clk) tick_in = 1'b1;
    repeat (3 + $urandom_range(0, 2)) @(negedge clk);
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
    if (adv) tod = (tod + 1) % 86400;
    check({tag, "_sp"}, sec_seen - s0, adv);
    check({tag, "_dp"}, day_seen - d0, day);
    check_time(tag);
  endtask

  task automatic do_glitch();
    int s0;
    bit adv;
    adv = run_en && !set_mode;
    s0 = sec_seen;
    @(negedge clk);
    #3 tick_in = 1'b1;
    #4 tick_in = 1'b0;
    repeat (5) @(negedge clk);
    if (adv) tod = (tod + 1) % 86400;
    check("glitch_sp", sec_seen - s0, adv);
    check_time("glitch");
  endtask

  task automatic do_inc(input bit im, input bit ih, input int n);
    int d0;
    d0 = day_seen;
    @(negedge clk);
    inc_min = im;
    inc_hr = ih;
    repeat (n) @(negedge clk);
    inc_min = 1'b0;
    inc_hr = 1'b0;
    @(negedge clk);
    if (set_mode) for (int i = 0; i < n; i++) model_inc(im, ih);
    check("inc_dp", day_seen - d0, 0);
    check_time("inc");
  endtask

  task automatic set_set_mode(input bit v);
    @(negedge clk) set_mode = v;
    @(negedge clk);
    if (v) tod = tod - (tod % 60);
    check_time(v ? "set_enter" : "set_leave");
  endtask

  task automatic goto_time(input int h, input int m, input int s);
    int dh, dm;
    set_set_mode(1'b1);
    dh = (h - tod / 3600 + 24) % 24;
    dm = (m - (tod / 60) % 60 + 60) % 60;
    if (dh > 0) do_inc(1'b0, 1'b1, dh);
    if (dm > 0) do_inc(1'b1, 1'b0, dm);
    set_set_mode(1'b0);
    run_en = 1'b1;
    for (int i = 0; i < s; i++) do_tick("goto");
  endtask

  task automatic reset_in_flight();
    @(negedge clk) tick_in = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pre_sp", sec_pulse, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    tod = 0;
    check("rst_async_sp", sec_pulse, 1'b0);
    check_time("rst_async");
    tick_in = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_time("rst_after");
  endtask

  initial begin
    #1_000_000;
    err_cnt++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    // reset with tick_in toggling
    repeat (4) #7 tick_in = ~tick_in;
    check_time("reset_hold");
    check("reset_sp", sec_pulse, 1'b0);
    check("reset_dp", day_pulse, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    run_en = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_sp", sec_seen, 0);
    check_time("idle");

    // first tick latency: digits change on the 3rd edge after the rise
    @(negedge clk) tick_in = 1'b1;
    repeat (2) @(negedge clk);
    check("lat_e2", sec_ones, 4'd0);
    @(negedge clk);
    check("lat_e3", sec_ones, 4'd1);
    check("lat_sp", sec_pulse, 1'b1);
    @(negedge clk);
    check("lat_sp_end", sec_pulse, 1'b0);
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
    tod = 1;

    // minute carry
    for (int i = 0; i < 58; i++) do_tick("run");
    do_tick("min_carry");
`ifndef TWELVE_HOUR_EN
    check("min_carry_lit", dut_digits, 24'h000100);
`endif

    // set mode from 10:20:35
    goto_time(10, 20, 35);
    set_set_mode(1'b1);
    do_inc(1'b1, 1'b0, 45);
    do_inc(1'b1, 1'b1, 1);
`ifndef TWELVE_HOUR_EN
    check("set_lit", dut_digits, 24'h110600);
`endif
    do_tick("set_ign");
    do_tick("set_ign");
    set_set_mode(1'b0);

    // day rollover
    goto_time(23, 59, 59);
    do_tick("day_roll");
`ifndef TWELVE_HOUR_EN
    check("day_lit", dut_digits, 24'h000000);
`endif

    // pause, ignored inc, glitch
    run_en = 1'b0;
    for (int i = 0; i < 5; i++) do_tick("pause");
    do_inc(1'b1, 1'b1, 2);
    run_en = 1'b1;
    do_glitch();

    // noon and 12:59:59 crossings
    goto_time(11, 59, 59);
    do_tick("noon");
    goto_time(12, 59, 59);
    do_tick("one_pm");

    // random operations
    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          run_en = ($urandom_range(0, 3) != 0);
          do_tick("rnd_tick");
        end
        4: set_set_mode(~set_mode);
        5, 6: do_inc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 4));
        7: do_glitch();
        8: begin
          set_set_mode(1'b0);
          goto_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(55, 59));
          do_tick("rnd_wrap");
        end
        default: begin
          set_set_mode(1'b0);
          run_en = 1'b1;
          reset_in_flight();
        end
      endcase
    end

    check("day_with_sec", day_alone, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
